gamma_phase_encoder: RTL and testbench

GAMMA_PHASE_ENCODER -- requirements
Module: gamma_phase_encoder

---
 rtl/gamma_phase_encoder.sv | 130 +++++++++++++
 tb/tb_gamma_phase_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gamma_phase_encoder.sv
// Gamma-oscillation phase encoder: free-running 8-bit phase counter that reports,
// once per cycle, the phase of the first accepted spike plus spike/silence statistics.
module gamma_phase_encoder #(
  parameter logic [7:0] BLANK   = 8'd0,
  parameter logic [3:0] CNT_MAX = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sync_in,
  input  logic       spike_in,
  output logic [7:0] global_phase,
  output logic       cycle_start,
  output logic [7:0] actual_phase,
  output logic       fired,
  output logic [3:0] spike_count,
  output logic [7:0] silent_cycles
);

  logic [7:0] phase_q, phase_d;
  logic       cycle_start_q, cycle_start_d;
  logic [7:0] actual_phase_q, actual_phase_d;
  logic       fired_q, fired_d;
  logic [3:0] spike_count_q, spike_count_d;
  logic [7:0] silent_q, silent_d;
  logic [7:0] cap_phase_q, cap_phase_d;
  logic       have_q, have_d;
  logic [3:0] cnt_q, cnt_d;

  logic       boundary_s;
  logic       accept_s;
  logic [8:0] phase_diff_s;

  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    cnt_inc = (c >= CNT_MAX) ? CNT_MAX : c + 4'd1;
  endfunction

  function automatic logic [7:0] silent_inc(input logic [7:0] s);
    silent_inc = (s == 8'd255) ? 8'd255 : s + 8'd1;
  endfunction

  // Blanking test by subtraction keeps the check meaningful even when BLANK is zero.
  assign phase_diff_s = {1'b0, phase_q} - {1'b0, BLANK};
  assign accept_s     = enable & spike_in & ~phase_diff_s[8];
  assign boundary_s   = enable & ((phase_q == 8'd255) | sync_in);

  // Next-state: phase counting, per-cycle capture and boundary reporting.
  always_comb begin
    phase_d        = phase_q;
    cycle_start_d  = 1'b0;
    actual_phase_d = actual_phase_q;
    fired_d        = fired_q;
    spike_count_d  = spike_count_q;
    silent_d       = silent_q;
    cap_phase_d    = cap_phase_q;
    have_d         = have_q;
    cnt_d          = cnt_q;

    if (boundary_s) begin
      phase_d       = 8'd0;
      cycle_start_d = 1'b1;
      have_d        = 1'b0;
      cnt_d         = 4'd0;
      if (have_q) begin
        // A spike landing on the closing edge still counts toward the closing cycle.
        actual_phase_d = cap_phase_q;
        fired_d        = 1'b1;
        spike_count_d  = accept_s ? cnt_inc(cnt_q) : cnt_q;
        silent_d       = 8'd0;
      end else if (accept_s) begin
        actual_phase_d = phase_q;
        fired_d        = 1'b1;
        spike_count_d  = 4'd1;
        silent_d       = 8'd0;
      end else begin
        fired_d       = 1'b0;
        spike_count_d = 4'd0;
        silent_d      = silent_inc(silent_q);
      end
    end else if (enable) begin
      phase_d = phase_q + 8'd1;
      if (accept_s) begin
        if (have_q) begin
          cnt_d = cnt_inc(cnt_q);
        end else begin
          cap_phase_d = phase_q;
          have_d      = 1'b1;
          cnt_d       = 4'd1;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q        <= 8'd0;
      cycle_start_q  <= 1'b0;
      actual_phase_q <= 8'd0;
      fired_q        <= 1'b0;
      spike_count_q  <= 4'd0;
      silent_q       <= 8'd0;
      cap_phase_q    <= 8'd0;
      have_q         <= 1'b0;
      cnt_q          <= 4'd0;
    end else begin
      phase_q        <= phase_d;
      cycle_start_q  <= cycle_start_d;
      actual_phase_q <= actual_phase_d;
      fired_q        <= fired_d;
      spike_count_q  <= spike_count_d;
      silent_q       <= silent_d;
      cap_phase_q    <= cap_phase_d;
      have_q         <= have_d;
      cnt_q          <= cnt_d;
    end
  end

  assign global_phase  = phase_q;
  assign cycle_start   = cycle_start_q;
  assign actual_phase  = actual_phase_q;
  assign fired         = fired_q;
  assign spike_count   = spike_count_q;
  assign silent_cycles = silent_q;

endmodule

// File: tb/tb_gamma_phase_encoder.sv
// Scoreboard bench for gamma_phase_encoder: two instances (BLANK=0 and BLANK=16)
// share stimulus; each has its own reference model and expected-report queue.
module tb_gamma_phase_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sync_in = 1'b0;
  logic spike_in = 1'b0;

  logic [7:0] gp [2];
  logic       cs [2];
  logic [7:0] ap [2];
  logic       fd [2];
  logic [3:0] sc [2];
  logic [7:0] sil [2];

  always #5 clk = ~clk;

  gamma_phase_encoder #(.BLANK(8'd0), .CNT_MAX(4'd15)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync_in(sync_in), .spike_in(spike_in),
    .global_phase(gp[0]), .cycle_start(cs[0]), .actual_phase(ap[0]), .fired(fd[0]),
    .spike_count(sc[0]), .silent_cycles(sil[0]));

  gamma_phase_encoder #(.BLANK(8'd16), .CNT_MAX(4'd15)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync_in(sync_in), .spike_in(spike_in),
    .global_phase(gp[1]), .cycle_start(cs[1]), .actual_phase(ap[1]), .fired(fd[1]),
    .spike_count(sc[1]), .silent_cycles(sil[1]));

  typedef struct {
    int act;
    int fired;
    int cnt;
    int sil;
  } rep_t;

  rep_t q0[$];
  rep_t q1[$];

  int checks = 0;
  int errors = 0;

  int blank_v [2] = '{0, 16};
  int m_phase [2];
  int m_cs [2];
  int m_first [2];
  int m_cnt [2];
  int m_sil [2];
  int m_lastact [2];
  rep_t held [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i, input logic r, input logic e, input logic s, input logic k);
    rep_t x;
    if (!r) begin
      m_phase[i] = 0; m_cs[i] = 0; m_first[i] = -1; m_cnt[i] = 0;
      m_sil[i] = 0; m_lastact[i] = 0;
      if (i == 0) q0.delete(); else q1.delete();
    end else if (e) begin
      if (k && m_phase[i] >= blank_v[i]) begin
        if (m_first[i] < 0) m_first[i] = m_phase[i];
        m_cnt[i] = (m_cnt[i] >= 15) ? 15 : m_cnt[i] + 1;
      end
      if (m_phase[i] == 255 || s) begin
        if (m_first[i] >= 0) begin
          x.act = m_first[i]; x.fired = 1; x.cnt = m_cnt[i];
          m_sil[i] = 0; m_lastact[i] = m_first[i];
        end else begin
          x.act = m_lastact[i]; x.fired = 0; x.cnt = 0;
          m_sil[i] = (m_sil[i] >= 255) ? 255 : m_sil[i] + 1;
        end
        x.sil = m_sil[i];
        if (i == 0) q0.push_back(x); else q1.push_back(x);
        m_first[i] = -1; m_cnt[i] = 0; m_phase[i] = 0; m_cs[i] = 1;
      end else begin
        m_phase[i] = m_phase[i] + 1;
        m_cs[i] = 0;
      end
    end else begin
      m_cs[i] = 0;
    end
  endtask

  task automatic check_dut(input int i, input logic r);
    rep_t x;
    if (!r) held[i] = '{0, 0, 0, 0};
    check_eq($sformatf("phase%0d", i), int'(gp[i]), m_phase[i]);
    check_eq($sformatf("cs%0d", i), int'(cs[i]), m_cs[i]);
    if (cs[i] === 1'b1) begin
      if (i == 0 && q0.size() > 0) begin
        x = q0.pop_front(); held[i] = x;
      end else if (i == 1 && q1.size() > 0) begin
        x = q1.pop_front(); held[i] = x;
      end else begin
        check_eq($sformatf("cs_unexpected%0d", i), int'(cs[i]), 0);
      end
    end
    check_eq($sformatf("act%0d", i), int'(ap[i]), held[i].act);
    check_eq($sformatf("fired%0d", i), int'(fd[i]), held[i].fired);
    check_eq($sformatf("count%0d", i), int'(sc[i]), held[i].cnt);
    check_eq($sformatf("silent%0d", i), int'(sil[i]), held[i].sil);
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic k);
    @(negedge clk);
    rst_n = r; enable = e; sync_in = s; spike_in = k;
    for (int i = 0; i < 2; i++) model_edge(i, r, e, s, k);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_dut(i, r);
  endtask

  // One full 256-edge cycle from phase 0, spiking where the mask function says.
  task automatic run_cycle(input int mode);
    logic k;
    for (int n = 0; n < 256; n++) begin
      case (mode)
        0: k = (m_phase[0] == 40);
        1: k = (m_phase[0] == 10 || m_phase[0] == 20 || m_phase[0] == 30);
        2: k = (m_phase[0] >= 100 && m_phase[0] < 120);
        3: k = (m_phase[0] == 255);
        4: k = (m_phase[0] == 8);
        5: k = (m_phase[0] == 0);
        default: k = 1'b0;
      endcase
      step(1'b1, 1'b1, 1'b0, k);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_edge(i, 1'b0, 1'b0, 1'b0, 1'b0);
      held[i] = '{0, 0, 0, 0};
    end
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("reset_phase", int'(gp[0]), 0);
    check_eq("reset_fired", int'(fd[0]), 0);

    run_cycle(0);
    check_eq("r030_cs", int'(cs[0]), 1);
    check_eq("r030_act", int'(ap[0]), 40);
    check_eq("r030_cnt", int'(sc[0]), 1);
    run_cycle(1);
    check_eq("r031_act", int'(ap[0]), 10);
    check_eq("r031_cnt", int'(sc[0]), 3);
    run_cycle(2);
    check_eq("r031_sat", int'(sc[0]), 15);
    run_cycle(3);
    check_eq("r032_act255", int'(ap[0]), 255);
    check_eq("r032_fired", int'(fd[0]), 1);
    for (int c = 0; c < 3; c++) run_cycle(4);
    check_eq("r033_fired", int'(fd[1]), 0);
    check_eq("r033_act_held", int'(ap[1]), 255);
    check_eq("r033_silent", int'(sil[1]), 3);
    run_cycle(5);
    check_eq("r032_act0", int'(ap[0]), 0);

    // Short cycle closed by sync_in at phase 100, then a frozen stretch.
    for (int n = 0; n < 300; n++) begin
      step(1'b1, 1'b1, m_phase[0] == 100, m_phase[0] == 50);
      if (m_cs[0] == 1) break;
    end
    check_eq("r034_phase", int'(gp[0]), 0);
    check_eq("r034_cs", int'(cs[0]), 1);
    check_eq("r034_act", int'(ap[0]), 50);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("r034_frozen", int'(gp[0]), 0);

    // sync_in coinciding with phase 255 must give a single boundary.
    for (int n = 0; n < 256; n++) step(1'b1, 1'b1, m_phase[0] == 255, m_phase[0] == 77);
    check_eq("r023_act", int'(ap[0]), 77);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r023_single", int'(gp[0]), 1);

    for (int n = 0; n < 800; n++)
      step(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);

    for (int n = 0; n < 600; n++) begin
      if (m_phase[0] == 200) break;
      step(1'b1, 1'b1, 1'b0, m_phase[0] == 60 || m_phase[0] == 150);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("r035_phase", int'(gp[0]), 0);
    check_eq("r035_act", int'(ap[0]), 0);
    check_eq("r035_sil", int'(sil[0]), 0);
    for (int n = 0; n < 255; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r035_no_early_cs", int'(cs[0]), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r035_cs", int'(cs[0]), 1);
    check_eq("r035_fired", int'(fd[0]), 0);

    check_eq("queue0_drained", q0.size(), 0);
    check_eq("queue1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
